maxpool2d: RTL and testbench

Streaming max-pooling stage placed directly downstream of the convolution/ReLU stage in the keyword-spotting CNN. Captures one full feature map (same flat packing the convolution stage produces), reduces it with non-overlapping max windows one output position per cycle, then presents the pooled map with a one-cycle valid strobe. Frames arriving while a reduction is in progress are dropped and flagged.

---
 rtl/maxpool2d.sv | 111 +++++++++++
 tb/tb_maxpool2d.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2d.sv
// Streaming 2-D max-pooling stage: captures one feature map, reduces one output
// position per cycle across all filters, then publishes the pooled map with a valid strobe.
`timescale 1ns/1ps

module maxpool2d #(
    parameter int INPUT_WIDTH  = 40,
    parameter int INPUT_HEIGHT = 1,
    parameter int NUM_FILTERS  = 8,
    parameter int POOL_WIDTH   = 2,
    parameter int POOL_HEIGHT  = 1,
    parameter int ACTIV_BITS   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [INPUT_WIDTH*INPUT_HEIGHT*NUM_FILTERS*ACTIV_BITS-1:0] data_in,
    input  logic data_valid,
    output logic [(INPUT_WIDTH/POOL_WIDTH)*(INPUT_HEIGHT/POOL_HEIGHT)*NUM_FILTERS*ACTIV_BITS-1:0] data_out,
    output logic data_out_valid,
    output logic busy,
    output logic overrun
);

    localparam int OUT_W     = INPUT_WIDTH / POOL_WIDTH;
    localparam int OUT_H     = INPUT_HEIGHT / POOL_HEIGHT;
    localparam int N         = OUT_W * OUT_H;
    localparam int IN_BITS   = INPUT_WIDTH * INPUT_HEIGHT * NUM_FILTERS * ACTIV_BITS;
    localparam int SLOT_BITS = NUM_FILTERS * ACTIV_BITS;
    localparam int OUT_BITS  = N * SLOT_BITS;
    localparam int IDX_W     = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {IDLE, POOL, DONE} state_t;

    state_t state_q, state_d;
    logic [IDX_W-1:0] idx;
    logic [IN_BITS-1:0] in_buf;
    logic [OUT_BITS-1:0] result;
    logic [SLOT_BITS-1:0] pooled;
    int win_row, win_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (data_valid) state_d = POOL;
            POOL:    if (idx == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    // Top-left input coordinate of the window for the current output position.
    assign win_row = (int'(idx) / OUT_W) * POOL_HEIGHT;
    assign win_col = (int'(idx) % OUT_W) * POOL_WIDTH;

    // Running unsigned max starting from zero equals the window max; ties are harmless.
    always_comb begin
        pooled = '0;
        for (int f = 0; f < NUM_FILTERS; f++) begin
            for (int ph = 0; ph < POOL_HEIGHT; ph++) begin
                for (int pw = 0; pw < POOL_WIDTH; pw++) begin
                    if (in_buf[(((win_row + ph) * INPUT_WIDTH + win_col + pw) * NUM_FILTERS + f) * ACTIV_BITS +: ACTIV_BITS]
                        > pooled[f * ACTIV_BITS +: ACTIV_BITS])
                        pooled[f * ACTIV_BITS +: ACTIV_BITS] =
                            in_buf[(((win_row + ph) * INPUT_WIDTH + win_col + pw) * NUM_FILTERS + f) * ACTIV_BITS +: ACTIV_BITS];
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the frame buffers are reset on purpose so a reset never exposes stale data.
            in_buf         <= '0;
            result         <= '0;
            data_out       <= '0;
            idx            <= '0;
            data_out_valid <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            data_out_valid <= 1'b0;
            overrun        <= data_valid && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (data_valid) begin
                        in_buf <= data_in;
                        idx    <= '0;
                    end
                end
                POOL: begin
                    result[int'(idx) * SLOT_BITS +: SLOT_BITS] <= pooled;
                    if (idx != LAST_IDX) idx <= idx + 1'b1;
                end
                DONE: begin
                    data_out       <= result;
                    data_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool2d.sv
// Directed bench for maxpool2d: default 40x1 / 2x1 instance plus a 5x4 / 2x2 odd-geometry instance.
`timescale 1ns/1ps

module tb_maxpool2d;

    localparam int IW = 40;
    localparam int NF = 8;
    localparam int AB = 8;
    localparam int OW = 20;
    localparam int IN_BITS  = IW * NF * AB;
    localparam int OUT_BITS = OW * NF * AB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic [IN_BITS-1:0]  data_in;
    logic                data_valid;
    logic [OUT_BITS-1:0] data_out;
    logic                data_out_valid, busy, overrun;

    logic [319:0] o_data_in;
    logic         o_data_valid;
    logic [63:0]  o_data_out;
    logic         o_valid, o_busy, o_overrun;

    int compared   = 0;
    int mismatched = 0;

    maxpool2d dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .data_out(data_out), .data_out_valid(data_out_valid), .busy(busy), .overrun(overrun)
    );

    maxpool2d #(
        .INPUT_WIDTH(5), .INPUT_HEIGHT(4), .NUM_FILTERS(2),
        .POOL_WIDTH(2), .POOL_HEIGHT(2), .ACTIV_BITS(8)
    ) dut_odd (
        .clk(clk), .rst_n(rst_n), .data_in(o_data_in), .data_valid(o_data_valid),
        .data_out(o_data_out), .data_out_valid(o_valid), .busy(o_busy), .overrun(o_overrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns #1 after the capture edge E0.
    task automatic send_frame(input logic [IN_BITS-1:0] frame);
        data_in    = frame;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
    endtask

    // Steps up to limit edges; first = edge index of the first valid pulse (-1 if none).
    task automatic wait_valid(input int limit, output int first, output int pulses);
        first  = -1;
        pulses = 0;
        for (int k = 1; k <= limit; k++) begin
            step();
            if (data_out_valid) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
    endtask

    function automatic logic [IN_BITS-1:0] ramp_frame();
        logic [IN_BITS-1:0] fr = '0;
        for (int w = 0; w < IW; w++)
            for (int f = 0; f < NF; f++)
                fr[(w * NF + f) * AB +: AB] = 8'(2 * w + f);
        return fr;
    endfunction

    function automatic logic [OUT_BITS-1:0] ramp_expected();
        logic [OUT_BITS-1:0] ex = '0;
        for (int c = 0; c < OW; c++)
            for (int f = 0; f < NF; f++)
                ex[(c * NF + f) * AB +: AB] = 8'(4 * c + 2 + f);
        return ex;
    endfunction

    // Reversed ramp: each pair holds 255-(4c+f) and 255-(4c+2+f); the max is the first.
    function automatic logic [IN_BITS-1:0] rev_frame();
        logic [IN_BITS-1:0] fr = '0;
        for (int w = 0; w < IW; w++)
            for (int f = 0; f < NF; f++)
                fr[(w * NF + f) * AB +: AB] = 8'(255 - 2 * w - f);
        return fr;
    endfunction

    function automatic logic [OUT_BITS-1:0] rev_expected();
        logic [OUT_BITS-1:0] ex = '0;
        for (int c = 0; c < OW; c++)
            for (int f = 0; f < NF; f++)
                ex[(c * NF + f) * AB +: AB] = 8'(255 - 4 * c - f);
        return ex;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; data_valid = 1'b0; data_in = '0;
        o_data_valid = 1'b0; o_data_in = '0;
        step(); step();
        compared++; if (data_out !== '0) begin mismatched++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
        compared++; if (data_out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", data_out_valid); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
        compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        rst_n = 1'b1;
        step();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_ramp();
        int first, pulses;
        send_frame(ramp_frame());
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL ramp_busy: got %b expected 1", busy); end
        wait_valid(25, first, pulses);
        compared++; if (first != 21) begin mismatched++; $display("FAIL ramp_latency: got %0d expected 21", first); end
        compared++; if (pulses != 1) begin mismatched++; $display("FAIL ramp_pulses: got %0d expected 1", pulses); end
        compared++; if (data_out !== ramp_expected()) begin mismatched++; $display("FAIL ramp_data: got %h expected %h", data_out, ramp_expected()); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL ramp_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_max_ties();
        int first, pulses;
        logic [IN_BITS-1:0]  fr = '0;
        logic [OUT_BITS-1:0] ex = '0;
        fr[(0 * NF) * AB +: AB] = 8'd200; fr[(1 * NF) * AB +: AB] = 8'd17;
        fr[(2 * NF) * AB +: AB] = 8'd17;  fr[(3 * NF) * AB +: AB] = 8'd200;
        fr[(4 * NF) * AB +: AB] = 8'd99;  fr[(5 * NF) * AB +: AB] = 8'd99;
        fr[(6 * NF) * AB +: AB] = 8'd255; fr[(7 * NF) * AB +: AB] = 8'd0;
        ex[(0 * NF) * AB +: AB] = 8'd200; ex[(1 * NF) * AB +: AB] = 8'd200;
        ex[(2 * NF) * AB +: AB] = 8'd99;  ex[(3 * NF) * AB +: AB] = 8'd255;
        send_frame(fr);
        wait_valid(25, first, pulses);
        compared++; if (first != 21) begin mismatched++; $display("FAIL max_latency: got %0d expected 21", first); end
        compared++; if (data_out !== ex) begin mismatched++; $display("FAIL max_data: got %h expected %h", data_out, ex); end
        send_frame('0);
        wait_valid(25, first, pulses);
        compared++; if (first != 21) begin mismatched++; $display("FAIL zero_latency: got %0d expected 21", first); end
        compared++; if (data_out !== '0) begin mismatched++; $display("FAIL zero_data: got %h expected 0", data_out); end
    endtask

    task automatic test_overrun();
        int first, pulses;
        send_frame(ramp_frame());
        for (int k = 1; k <= 4; k++) step();
        data_in    = {(IN_BITS/8){8'hAA}};
        data_valid = 1'b1;
        step();                                  // rejected edge E5
        data_valid = 1'b0;
        compared++; if (overrun !== 1'b1) begin mismatched++; $display("FAIL overrun_pulse: got %b expected 1", overrun); end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL overrun_busy: got %b expected 1", busy); end
        step();                                  // E6
        compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL overrun_drop: got %b expected 0", overrun); end
        wait_valid(20, first, pulses);           // E7..E26
        compared++; if (first != 15) begin mismatched++; $display("FAIL overrun_latency: got E%0d expected E21", first + 6); end
        compared++; if (pulses != 1) begin mismatched++; $display("FAIL overrun_pulses: got %0d expected 1", pulses); end
        compared++; if (data_out !== ramp_expected()) begin mismatched++; $display("FAIL overrun_data: got %h expected %h", data_out, ramp_expected()); end
    endtask

    task automatic test_back_to_back();
        logic saw_overrun = 1'b0;
        logic stable      = 1'b1;
        int   early       = 0;
        send_frame(ramp_frame());
        for (int k = 1; k <= 20; k++) begin
            step();
            if (overrun) saw_overrun = 1'b1;
            if (data_out_valid) early++;
        end
        step();                                  // E21
        compared++; if (data_out_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_first_valid: got %b expected 1", data_out_valid); end
        compared++; if (data_out !== ramp_expected()) begin mismatched++; $display("FAIL b2b_first_data: got %h expected %h", data_out, ramp_expected()); end
        data_in    = rev_frame();
        data_valid = 1'b1;
        for (int k = 22; k <= 42; k++) begin
            step();
            data_valid = 1'b0;
            if (overrun) saw_overrun = 1'b1;
            if (data_out_valid) early++;
            if (data_out !== ramp_expected()) stable = 1'b0;
        end
        step();                                  // E43
        compared++; if (data_out_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_second_valid: got %b expected 1", data_out_valid); end
        compared++; if (data_out !== rev_expected()) begin mismatched++; $display("FAIL b2b_second_data: got %h expected %h", data_out, rev_expected()); end
        compared++; if (early != 0) begin mismatched++; $display("FAIL b2b_stray_valid: got %0d pulses expected 0", early); end
        compared++; if (stable !== 1'b1) begin mismatched++; $display("FAIL b2b_hold: got unstable expected stable"); end
        compared++; if (saw_overrun !== 1'b0) begin mismatched++; $display("FAIL b2b_overrun: got %b expected 0", saw_overrun); end
        step();
    endtask

    task automatic test_reset_mid();
        int first, pulses;
        send_frame(ramp_frame());
        for (int k = 1; k <= 10; k++) step();    // E10
        rst_n = 1'b0;
        #1;
        compared++; if (data_out !== '0) begin mismatched++; $display("FAIL mid_reset_data: got %h expected 0", data_out); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
        compared++; if (data_out_valid !== 1'b0 || overrun !== 1'b0) begin mismatched++; $display("FAIL mid_reset_strobes: got %b%b expected 00", data_out_valid, overrun); end
        step(); step();
        rst_n = 1'b1;
        wait_valid(25, first, pulses);
        compared++; if (pulses != 0) begin mismatched++; $display("FAIL mid_reset_no_valid: got %0d pulses expected 0", pulses); end
        send_frame(rev_frame());
        wait_valid(25, first, pulses);
        compared++; if (first != 21) begin mismatched++; $display("FAIL mid_reset_latency: got %0d expected 21", first); end
        compared++; if (data_out !== rev_expected()) begin mismatched++; $display("FAIL mid_reset_data_after: got %h expected %h", data_out, rev_expected()); end
    endtask

    task automatic test_odd_geometry();
        int tbl [20] = '{3, 9, 4, 1, 250,
                         7, 2, 8, 6, 250,
                         5, 0, 12, 10, 250,
                         1, 14, 11, 13, 250};
        logic [63:0] ex = {8'd245, 8'd13, 8'd255, 8'd14, 8'd254, 8'd8, 8'd253, 8'd9};
        int first = -1;
        for (int i = 0; i < 20; i++) begin
            o_data_in[(i * 2 + 0) * 8 +: 8] = 8'(tbl[i]);
            o_data_in[(i * 2 + 1) * 8 +: 8] = 8'(255 - tbl[i]);
        end
        o_data_valid = 1'b1;
        step();
        o_data_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (o_valid && first < 0) first = k;
        end
        compared++; if (first != 5) begin mismatched++; $display("FAIL odd_latency: got %0d expected 5", first); end
        compared++; if (o_data_out !== ex) begin mismatched++; $display("FAIL odd_data: got %h expected %h", o_data_out, ex); end
        compared++; if (o_busy !== 1'b0) begin mismatched++; $display("FAIL odd_busy: got %b expected 0", o_busy); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_max_ties();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_odd_geometry();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
